sump_cmd_decoder: RTL and testbench

Byte-to-command assembler between the UART receiver and the logic-sniffer core in the Terasic_DE1 design. It takes received bytes, frames them into SUMP commands and presents each complete command to the core as a single-cycle strobe. Short commands are one opcode byte with bit 7 = 0. Long commands are an opcode with bit 7 = 1 followed by a 4-byte little-endian argument. A watchdog drops partial long commands when the host stops sending, so the decoder re-synchronises on its own.

---
 rtl/sump_cmd_decoder.sv | 108 ++++++++++
 tb/tb_sump_cmd_decoder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sump_cmd_decoder.sv
// Frames received UART bytes into SUMP commands: 1-byte short opcodes (bit 7 = 0) or a long
// opcode (bit 7 = 1) followed by a 4-byte little-endian argument, with a watchdog resync.
module sump_cmd_decoder #(
    parameter int unsigned TIMEOUT = 65536,
    parameter int unsigned TW      = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        cmd_valid,
    output logic        cmd_long,
    output logic [7:0]  cmd_op,
    output logic [31:0] cmd_data,
    output logic        busy,
    output logic        err_timeout
);

    typedef enum logic [0:0] {IDLE, ARG} state_t;

    localparam bit            WDOG_EN = (TIMEOUT != 0);
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t        r_state;
    logic [1:0]    r_idx;
    logic [TW-1:0] r_wdog;
    logic [7:0]    r_op;
    logic [31:0]   r_arg;
    logic          r_cmd_valid;
    logic          r_cmd_long;
    logic [7:0]    r_cmd_op;
    logic [31:0]   r_cmd_data;
    logic          r_busy;
    logic          r_err_timeout;

    // Opcode/argument are assembled in shadow registers so the command outputs only change on a
    // completed command and survive a watchdog abort untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_idx         <= 2'd0;
            r_wdog        <= '0;
            r_op          <= 8'h00;
            r_arg         <= 32'h0;
            r_cmd_valid   <= 1'b0;
            r_cmd_long    <= 1'b0;
            r_cmd_op      <= 8'h00;
            r_cmd_data    <= 32'h0;
            r_busy        <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_cmd_valid   <= 1'b0;
            r_err_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (rx_valid) begin
                        r_op   <= rx_data;
                        r_arg  <= 32'h0;
                        r_idx  <= 2'd0;
                        r_wdog <= '0;
                        if (rx_data[7]) begin
                            r_state <= ARG;
                            r_busy  <= 1'b1;
                        end else begin
                            r_cmd_valid <= 1'b1;
                            r_cmd_long  <= 1'b0;
                            r_cmd_op    <= rx_data;
                            r_cmd_data  <= 32'h0;
                        end
                    end
                end
                ARG: begin
                    // A byte landing on the expiry cycle wins over the watchdog.
                    if (rx_valid) begin
                        r_wdog               <= '0;
                        r_arg[8*r_idx +: 8]  <= rx_data;
                        if (r_idx == 2'd3) begin
                            r_state     <= IDLE;
                            r_busy      <= 1'b0;
                            r_cmd_valid <= 1'b1;
                            r_cmd_long  <= 1'b1;
                            r_cmd_op    <= r_op;
                            r_cmd_data  <= {rx_data, r_arg[23:0]};
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end else if (WDOG_EN && r_wdog == TO_LAST) begin
                        r_state       <= IDLE;
                        r_busy        <= 1'b0;
                        r_err_timeout <= 1'b1;
                        r_wdog        <= '0;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_valid   = r_cmd_valid;
    assign cmd_long    = r_cmd_long;
    assign cmd_op      = r_cmd_op;
    assign cmd_data    = r_cmd_data;
    assign busy        = r_busy;
    assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Directed bench for sump_cmd_decoder: stimulus pushes expected strobes to a queue, a negedge
// monitor pops and compares them, including the cycle each strobe must appear in.
module tb_sump_cmd_decoder;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        cmd_valid;
    logic        cmd_long;
    logic [7:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        busy;
    logic        err_timeout;

    typedef struct {
        bit          is_to;
        bit          lng;
        logic [7:0]  op;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    ev_t q[$];
    int  cyc    = 0;
    int  vecs   = 0;
    int  miss   = 0;
    bit  mon_on = 1'b0;

    sump_cmd_decoder #(.TIMEOUT(TO), .TW(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .cmd_valid   (cmd_valid),
        .cmd_long    (cmd_long),
        .cmd_op      (cmd_op),
        .cmd_data    (cmd_data),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input bit lng, input logic [7:0] op, input logic [31:0] data);
        ev_t e;
        e.is_to = 1'b0; e.lng = lng; e.op = op; e.data = data; e.cyc = cyc + 1;
        q.push_back(e);
    endtask

    task automatic push_to(input int at);
        ev_t e;
        e.is_to = 1'b1; e.lng = 1'b0; e.op = 8'h00; e.data = 32'h0; e.cyc = at;
        q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_short(input logic [7:0] op);
        push_cmd(1'b0, op, 32'h0);
        send_byte(op);
    endtask

    task automatic send_long(input logic [7:0] op, input logic [31:0] data, input int g);
        send_byte(op);
        chk("busy_after_op", busy, 1);
        for (int i = 0; i < 4; i++) begin
            gap(g);
            if (i == 3) push_cmd(1'b1, op, data);
            send_byte(data[8*i +: 8]);
            if (i < 3) chk("busy_mid_arg", busy, 1);
        end
        chk("busy_at_cmd", busy, 0);
    endtask

    // Monitor: every strobe must match the head of the scoreboard, in the expected cycle.
    always @(negedge clk) begin
        if (mon_on && (cmd_valid || err_timeout)) begin
            if (q.size() == 0) begin
                chk("spurious_strobe", {cmd_valid, err_timeout}, 0);
            end else begin
                ev_t e;
                e = q.pop_front();
                chk("strobe_cycle", cyc, e.cyc);
                chk("err_timeout", err_timeout, e.is_to);
                chk("cmd_valid", cmd_valid, !e.is_to);
                if (!e.is_to) begin
                    chk("cmd_long", cmd_long, e.lng);
                    chk("cmd_op", cmd_op, e.op);
                    chk("cmd_data", cmd_data, e.data);
                end
            end
        end
    end

    initial begin
        int t0;
        gap(2);
        chk("rst_outputs", {cmd_valid, cmd_long, cmd_op, cmd_data, busy, err_timeout}, 0);
        rst = 1'b1;
        mon_on = 1'b1;
        gap(2);

        send_short(8'h02);
        gap(3);

        send_long(8'h81, 32'h0004_0004, 3);
        gap(2);

        send_long(8'hC0, 32'h0000_00FF, 0);
        send_short(8'h01);
        gap(3);

        // Watchdog expiry: strobe TO+1 clocks after the last byte's rx_valid cycle.
        send_byte(8'hC2);
        push_to(cyc + 1 + TO);
        send_byte(8'h00);
        gap(TO + 4);
        chk("busy_after_to", busy, 0);
        chk("op_held_after_to", cmd_op, 8'h01);
        chk("data_held_after_to", cmd_data, 32'h0);
        send_short(8'h00);
        gap(2);

        // Bytes arriving exactly on the would-be expiry cycle keep the command alive.
        send_long(8'hC3, 32'h4433_2211, TO - 1);
        gap(2);

        send_byte(8'h82);
        send_byte(8'h00);
        rst = 1'b0;
        #1;
        chk("midcmd_rst", {cmd_valid, cmd_long, cmd_op, cmd_data, busy, err_timeout}, 0);
        @(negedge clk);
        rst = 1'b1;
        gap(1);
        send_short(8'h01);
        gap(2);

        for (int i = 0; i < 5; i++) send_short(8'h00);

        t0 = cyc;
        while (q.size() != 0 && cyc - t0 < 50) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        gap(TO + 4);
        mon_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
